// File: rtl/decoder24_scan.sv
// 2-to-4 one-hot decoder with a handshake-loaded hold register and an
// auto-scan mode that rotates the active bit every DWELL cycles.
module decoder24_scan #(
    parameter int DWELL = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       EN,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] x,
    input  logic       scan_en,
    output logic [3:0] y,
    output logic       y_valid,
    output logic [1:0] code
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_t;

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    state_t     state, state_nx;
    logic [1:0] code_nx;
    logic [3:0] y_nx;
    logic       y_valid_nx;
    logic [7:0] dwell, dwell_nx;
    logic [1:0] code_inc;

    function automatic logic [3:0] onehot(input logic [1:0] c);
        return 4'b0001 << c;
    endfunction

    // Gated by rst_n so the handshake is closed for the whole reset window.
    assign in_ready = rst_n && EN && !scan_en && (state == IDLE || state == HOLD);
    assign code_inc = code + 2'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            code    <= 2'd0;
            y       <= 4'd0;
            y_valid <= 1'b0;
            dwell   <= 8'd0;
        end else begin
            state   <= state_nx;
            code    <= code_nx;
            y       <= y_nx;
            y_valid <= y_valid_nx;
            dwell   <= dwell_nx;
        end
    end

    // Priority: EN low, then scan request, then code acceptance.
    always_comb begin
        state_nx   = state;
        code_nx    = code;
        y_nx       = y;
        y_valid_nx = y_valid;
        dwell_nx   = dwell;

        if (!EN) begin
            state_nx   = IDLE;
            code_nx    = 2'd0;
            y_nx       = 4'd0;
            y_valid_nx = 1'b0;
            dwell_nx   = 8'd0;
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (scan_en) begin
                        state_nx   = SCAN;
                        dwell_nx   = 8'd0;
                        y_valid_nx = 1'b1;
                        // Scan starts from the held code, or from bit 0 when nothing is held.
                        if (state == IDLE) begin
                            code_nx = 2'd0;
                            y_nx    = 4'b0001;
                        end else begin
                            y_nx = onehot(code);
                        end
                    end else if (in_valid && in_ready) begin
                        state_nx   = HOLD;
                        code_nx    = x;
                        y_nx       = onehot(x);
                        y_valid_nx = 1'b1;
                    end
                end
                SCAN: begin
                    if (!scan_en) begin
                        state_nx = HOLD;
                        dwell_nx = 8'd0;
                    end else if (dwell == DWELL_LAST) begin
                        dwell_nx = 8'd0;
                        code_nx  = code_inc;
                        y_nx     = onehot(code_inc);
                    end else begin
                        dwell_nx = dwell + 8'd1;
                    end
                end
                default: begin
                    state_nx   = IDLE;
                    code_nx    = 2'd0;
                    y_nx       = 4'd0;
                    y_valid_nx = 1'b0;
                    dwell_nx   = 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decoder24_scan.sv
// Directed bench for decoder24_scan: one instance with DWELL=4 and one with
// DWELL=1 share every input so both scan rates are checked in the same run.
module tb_decoder24_scan;

    logic       clk;
    logic       rst_n;
    logic       EN;
    logic       in_valid;
    logic [1:0] x;
    logic       scan_en;

    logic       in_ready4, in_ready1;
    logic [3:0] y4, y1;
    logic       y_valid4, y_valid1;
    logic [1:0] code4, code1;

    int checks   = 0;
    int failures = 0;

    decoder24_scan #(.DWELL(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .EN(EN), .in_valid(in_valid),
        .in_ready(in_ready4), .x(x), .scan_en(scan_en),
        .y(y4), .y_valid(y_valid4), .code(code4)
    );

    decoder24_scan #(.DWELL(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .EN(EN), .in_valid(in_valid),
        .in_ready(in_ready1), .x(x), .scan_en(scan_en),
        .y(y1), .y_valid(y_valid1), .code(code1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic v, input logic [1:0] xv, input logic s);
        EN       = en;
        in_valid = v;
        x        = xv;
        scan_en  = s;
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkState4(input string tag, input logic [3:0] ey, input logic [1:0] ec,
                               input logic ev, input logic er);
        checkOutput({tag, ".y"},     {4'd0, y4},        {4'd0, ey});
        checkOutput({tag, ".code"},  {6'd0, code4},     {6'd0, ec});
        checkOutput({tag, ".valid"}, {7'd0, y_valid4},  {7'd0, ev});
        checkOutput({tag, ".ready"}, {7'd0, in_ready4}, {7'd0, er});
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0);
        #2;
        checkState4("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        checkOutput("reset.dut1_ready", {7'd0, in_ready1}, 8'd0);
        #11 rst_n = 1'b1;

        // Single acceptance, then held while in_valid is low and x moves.
        applyStimulus(1'b1, 1'b1, 2'd2, 1'b0);
        tick();
        checkState4("s1_accept", 4'b0100, 2'd2, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 2'd3, 1'b0);
        tick();
        checkState4("s1_hold", 4'b0100, 2'd2, 1'b1, 1'b1);

        // Back-to-back replacement, then EN low.
        applyStimulus(1'b1, 1'b1, 2'd3, 1'b0);
        tick();
        checkState4("s2_replace", 4'b1000, 2'd3, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 2'd3, 1'b0);
        tick();
        checkState4("s2_disable", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Scan from IDLE with DWELL=4.
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b1);
        #1;
        checkOutput("s3_ready_pre", {7'd0, in_ready4}, 8'd0);
        for (int i = 0; i < 17; i++) begin
            tick();
            checkOutput($sformatf("s3_y%0d", i), {4'd0, y4}, 8'(4'b0001 << ((i / 4) % 4)));
            checkOutput($sformatf("s3_rdy%0d", i), {7'd0, in_ready4}, 8'd0);
        end
        // Cycle 16 shown; step to cycle 24 where y=0100.
        for (int i = 0; i < 8; i++) tick();
        checkState4("s4_pre", 4'b0100, 2'd2, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0);
        tick();
        checkState4("s4_hold", 4'b0100, 2'd2, 1'b1, 1'b1);
        tick();
        checkState4("s4_stable", 4'b0100, 2'd2, 1'b1, 1'b1);

        // in_valid with scan_en from HOLD: scan wins, x not latched.
        applyStimulus(1'b1, 1'b1, 2'd1, 1'b1);
        tick();
        checkState4("s5_scan_hold", 4'b0100, 2'd2, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 2'd1, 1'b1);
        tick();
        checkState4("s5_en_prio", 4'b0000, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 2'd1, 1'b1);
        tick();
        checkState4("s5_scan_idle", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Asynchronous reset between edges during scan.
        tick();
        #2 rst_n = 1'b0;
        #1;
        checkState4("s6_rst4", 4'b0000, 2'd0, 1'b0, 1'b0);
        checkOutput("s6_rst1.y", {4'd0, y1}, 8'd0);
        checkOutput("s6_rst1.valid", {7'd0, y_valid1}, 8'd0);
        #2 rst_n = 1'b1;

        // DWELL=1 re-enters scan from IDLE and steps every cycle.
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput($sformatf("s6_d1_y%0d", i), {4'd0, y1}, 8'(4'b0001 << (i % 4)));
            checkOutput($sformatf("s6_d1_code%0d", i), {6'd0, code1}, 8'(i % 4));
        end
        // in_valid ignored while still scanning; last scanned value is held.
        applyStimulus(1'b1, 1'b1, 2'd3, 1'b0);
        tick();
        checkOutput("s6_d1_hold.y", {4'd0, y1}, 8'b0000_0001);
        checkOutput("s6_d1_hold.ready", {7'd0, in_ready1}, 8'd1);
        tick();
        checkOutput("s6_d1_accept.y", {4'd0, y1}, 8'b0000_1000);
        checkOutput("s6_d1_accept.code", {6'd0, code1}, 8'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decoder24_scan.md
DECODER24_SCAN -- requirements
Module: decoder24_scan

Interface
REQ-001 The module SHALL have parameter DWELL, default 4, giving the number of clock cycles each one-hot position is held in scan mode; legal range 1..255.
REQ-002 The module SHALL have port clk, input, 1, the single clock; every register updates on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1, the reset; it is asynchronous and active-low.
REQ-004 The module SHALL have port EN, input, 1, the global enable; low forces the block idle.
REQ-005 The module SHALL have port in_valid, input, 1, which qualifies x.
REQ-006 The module SHALL have port in_ready, output, 1, which signals that a code can be accepted this cycle.
REQ-007 The module SHALL have port x, input, 2, the binary code to decode.
REQ-008 The module SHALL have port scan_en, input, 1, which requests auto-scan of all four outputs.
REQ-009 The module SHALL have port y, output, 4, the registered one-hot decoded output.
REQ-010 The module SHALL have port y_valid, output, 1, high whenever y carries a decoded value.
REQ-011 The module SHALL have port code, output, 2, the binary index of the active bit of y.

Function
REQ-012 The block SHALL implement three states: IDLE, HOLD and SCAN.
REQ-013 in_ready SHALL be high only when EN=1, scan_en=0 and the state is IDLE or HOLD.
REQ-014 A code SHALL be accepted on a rising edge where in_valid && in_ready; x is latched into the code register.
REQ-015 Acceptance SHALL have 1-cycle latency: on the cycle after acceptance the state is HOLD, y = 1<<x, code = x and y_valid = 1.
REQ-016 In HOLD, y and code SHALL remain constant until the next acceptance, a transition to SCAN, or a transition to IDLE.
REQ-017 A new acceptance while in HOLD SHALL replace y and code on the next cycle, with no intervening zero cycle.
REQ-018 In IDLE or HOLD, EN=1 with scan_en=1 SHALL move the state to SCAN on the next edge and load the dwell counter with 0.
REQ-019 Outputs on the first SCAN cycle SHALL be as follows: y and code hold the current code register value when entering from HOLD, and y = 4'b0001, code = 0 when entering from IDLE.
REQ-020 In SCAN, the dwell counter SHALL increment every cycle.
REQ-021 When the dwell counter reaches DWELL-1, it SHALL reset to 0 and code SHALL advance by 1, wrapping 3 to 0, so that y rotates 0001 -> 0010 -> 0100 -> 1000 -> 0001.
REQ-022 With DWELL=1, code SHALL advance every cycle.
REQ-023 The dwell counter width SHALL be 8 bits, so it never overflows for legal DWELL values.
REQ-024 In SCAN, y_valid SHALL be 1 and in_ready SHALL be 0; in_valid is ignored.
REQ-025 In SCAN, scan_en=0 with EN=1 SHALL move the state to HOLD on the next edge.
REQ-026 On that transition, y and code SHALL keep the last scanned value, which becomes the held code.
REQ-027 EN=0 in any state SHALL move the state to IDLE on the next edge, with y = 0, code = 0, y_valid = 0 and the dwell counter cleared.
REQ-028 EN=0 SHALL have priority over scan_en and in_valid.
REQ-029 Priority among simultaneous requests SHALL be: EN=0 first, then scan_en=1, then acceptance; in_valid with scan_en=1 in the same cycle is not accepted.
REQ-030 In IDLE, y SHALL be 4'b0000 and y_valid SHALL be 0.
REQ-031 y SHALL never have more than one bit set.
REQ-032 y, y_valid and code SHALL be driven directly from registers.

Reset
REQ-033 While rst_n=0, the outputs SHALL be: state IDLE, y=0, code=0, y_valid=0, dwell counter=0, in_ready=0.
REQ-034 Reset SHALL take effect immediately, independent of clk.
REQ-035 Reset asserted mid-scan or mid-hold SHALL discard all state; no partial value persists.
REQ-036 After rst_n rises, the first acceptance is possible on the first clk edge at which in_valid, EN and in_ready are all high.

Verification
REQ-037 Scenario 1: EN=1, in_valid=1, x=2 for one cycle -> next cycle y=0100, code=2, y_valid=1, held while in_valid=0.
REQ-038 Scenario 2: in HOLD with x=2 held, accept x=3 -> next cycle y=1000 with no zero gap; then EN=0 -> next cycle y=0000, y_valid=0.
REQ-039 Scenario 3: DWELL=4, scan_en=1 from IDLE -> y=0001 for 4 cycles, then 0010, 0100, 1000 for 4 cycles each, then 0001 again; in_ready=0 throughout.
REQ-040 Scenario 4: scan_en dropped while y=0100 -> state HOLD, y stays 0100 and code=2; in_ready returns to 1.
REQ-041 Scenario 5: in_valid=1 and scan_en=1 in the same cycle with x=1 -> SCAN entered and x not latched; EN=0 simultaneously -> IDLE.
REQ-042 Scenario 6: rst_n pulsed low between clock edges during SCAN -> y=0, y_valid=0 immediately; DWELL=1 scan then steps y every cycle after re-entry.
